game_tick_gen: RTL

Multi-channel phase-accumulator tick generator for the obstacle game. It derives several independent low-rate timing signals from the 50 MHz system clock, for example the ~60 Hz frame tick, obstacle-step and animation rates. Each channel provides a one-cycle enable pulse and a 50 % square wave. Downstream logic stays on the single system clock and gates on the tick pulses, instead of clocking from a divided counter bit. Channel rate, mode and enable can be reprogrammed at run time.

---
 rtl/game_tick_gen.sv | 61 ++++++
 1 files changed

// File: rtl/game_tick_gen.sv
// game_tick_gen: multi-channel phase-accumulator tick generator with per-channel pulse, square wave and enable.
module game_tick_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 24,
  parameter int INC_W = 16,
  parameter int DEFAULT_INC = 20,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [INC_W-1:0]  wr_inc,
  input  logic              wr_mode,
  input  logic              wr_enable,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] busy
);
  logic [NUM_CH-1:0] wsel;
  // Out-of-range channel indices shift the select bit out, so those writes are dropped.
  assign wsel = wr_en ? (NUM_CH'(1) << wr_ch) : '0;
  for (genvar g = 0; g < NUM_CH; g++) begin : ch
    logic [ACC_W-1:0] acc;
    logic [INC_W-1:0] inc;
    logic             mode;
    logic             en;
    logic             tick_q;
    logic [ACC_W:0]   sum;
    assign sum = {1'b0, acc} + (ACC_W+1)'(inc);
    always_ff @(posedge clk) begin
      if (reset) begin
        acc <= '0;
        inc <= INC_W'(DEFAULT_INC);
        mode <= 1'b0;
        en <= 1'b1;
        tick_q <= 1'b0;
      end else if (wsel[g]) begin
        acc <= '0;
        inc <= wr_inc;
        mode <= wr_mode;
        en <= wr_enable;
        tick_q <= 1'b0;
      end else if (sync_clr) begin
        acc <= '0;
        tick_q <= 1'b0;
      end else if (pause || !en) begin
        tick_q <= 1'b0;
      end else begin
        acc <= sum[ACC_W-1:0];
        tick_q <= sum[ACC_W];
        if (sum[ACC_W] && mode) en <= 1'b0;
      end
    end
    assign tick[g] = tick_q;
    assign sq[g] = acc[ACC_W-1];
    assign busy[g] = en;
  end
endmodule
